tmds_decoder: RTL and testbench

// - Receive-side counterpart of the HDMI TMDS encoder: recovers one colour channel from
//   10-bit TMDS symbols, one symbol per pixel clock, arriving at an unknown bit phase.
// - Searches all 10 bit offsets for control tokens, locks word alignment, then decodes
//   8-bit video data, the DE flag and the 2 control bits.
// - Instantiated three times (red/grn/blu) behind a deserializer, for loopback checks

---
 rtl/tmds_decoder.sv | 191 +++++++++++++++++++
 tb/tb_tmds_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder.
// Slides a 10-bit window across two consecutive deserialised words until a
// steady run of control tokens is seen, then decodes video data, DE and the
// two control bits at that bit offset. Lock is dropped after a long stretch
// with no control token, and the search resumes at the next offset.
module tmds_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       i_pixclk,
    input  logic       i_reset,
    input  logic [9:0] i_tmds,
    output logic       o_locked,
    output logic [3:0] o_offset,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic [1:0] o_ctl
);

    localparam int RUN_W   = (CTRL_RUN > 1)       ? $clog2(CTRL_RUN)       : 1;
    localparam int TIMER_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int LOSS_W  = (LOSS_TIMEOUT > 1)   ? $clog2(LOSS_TIMEOUT)   : 1;

    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_RUN - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // True for the four TMDS control tokens.
    function automatic logic is_token(input logic [9:0] s);
        logic r;
        case (s)
            10'h354, 10'h0AB, 10'h154, 10'h2AB: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // {C1,C0} carried by a control token.
    function automatic logic [1:0] token_ctl(input logic [9:0] s);
        logic [1:0] r;
        case (s)
            10'h354: r = 2'b00;
            10'h0AB: r = 2'b01;
            10'h154: r = 2'b10;
            10'h2AB: r = 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Undo the optional inversion, then undo the XOR/XNOR transition chain.
    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [6:0] x;
        d = s[9] ? ~s[7:0] : s[7:0];
        x = d[7:1] ^ d[6:0];
        return {(s[8] ? x : ~x), d[0]};
    endfunction

    // Bit offsets cycle 0..9.
    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o == 4'd9) ? 4'd0 : o + 4'd1;
    endfunction

    logic [9:0]         prev_q,   prev_d;
    logic [9:0]         sym_q,    sym_d;
    logic [3:0]         off_q,    off_d;
    state_t             state_q,  state_d;
    logic [RUN_W-1:0]   run_q,    run_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [LOSS_W-1:0]  loss_q,   loss_d;
    logic               locked_q, locked_d;
    logic               de_q,     de_d;
    logic [7:0]         data_q,   data_d;
    logic [1:0]         ctl_q,    ctl_d;
    logic               sym_tok_s;

    // Pipeline steering, alignment search/lock state machine and output decode.
    always_comb begin
        prev_d    = i_tmds;
        sym_d     = 10'({i_tmds, prev_q} >> off_q);
        sym_tok_s = is_token(sym_q);

        state_d = state_q;
        off_d   = off_q;
        run_d   = run_q;
        timer_d = timer_q;
        loss_d  = loss_q;

        case (state_q)
            ST_SEARCH: begin
                loss_d = '0;
                if (sym_tok_s && (run_q == RUN_LAST)) begin
                    // A lock completing on the timeout cycle takes priority.
                    state_d = ST_LOCKED;
                    run_d   = '0;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    off_d   = next_offset(off_q);
                    run_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    run_d   = sym_tok_s ? run_q + RUN_W'(1) : '0;
                end
            end
            ST_LOCKED: begin
                run_d   = '0;
                timer_d = '0;
                if (sym_tok_s) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d = ST_SEARCH;
                    off_d   = next_offset(off_q);
                    loss_d  = '0;
                end else begin
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: begin
                state_d = ST_SEARCH;
                off_d   = 4'd0;
                run_d   = '0;
                timer_d = '0;
                loss_d  = '0;
            end
        endcase

        // Outputs follow the state being entered so lock/unlock and the
        // first/last decoded symbol appear on the same cycle.
        if (state_d == ST_LOCKED) begin
            locked_d = 1'b1;
            if (sym_tok_s) begin
                de_d   = 1'b0;
                data_d = 8'h00;
                ctl_d  = token_ctl(sym_q);
            end else begin
                de_d   = 1'b1;
                data_d = tmds_decode(sym_q);
                ctl_d  = ctl_q;
            end
        end else begin
            locked_d = 1'b0;
            de_d     = 1'b0;
            data_d   = 8'h00;
            ctl_d    = 2'b00;
        end
    end

    // All state and output registers, cleared immediately by reset.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            prev_q   <= 10'h000;
            sym_q    <= 10'h000;
            off_q    <= 4'd0;
            state_q  <= ST_SEARCH;
            run_q    <= '0;
            timer_q  <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
            de_q     <= 1'b0;
            data_q   <= 8'h00;
            ctl_q    <= 2'b00;
        end else begin
            prev_q   <= prev_d;
            sym_q    <= sym_d;
            off_q    <= off_d;
            state_q  <= state_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            loss_q   <= loss_d;
            locked_q <= locked_d;
            de_q     <= de_d;
            data_q   <= data_d;
            ctl_q    <= ctl_d;
        end
    end

    assign o_locked = locked_q;
    assign o_offset = off_q;
    assign o_de     = de_q;
    assign o_data   = data_q;
    assign o_ctl    = ctl_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: hand sequences for lock, loss, slip
// and reset behaviour, a decode vector table, and randomised serial streams
// (TMDS-encoded bytes and tokens at a random bit phase) scored per symbol.
module tb_tmds_decoder;

    localparam int CTRL_RUN  = 8;
    localparam int SEARCH_TO = 16;
    localparam int LOSS_TO   = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] tmds;
    logic       locked;
    logic [3:0] offset;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctl;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctl;
    } vec_t;

    vec_t       tab[10];
    logic [9:0] tok_tab[4];
    logic [9:0] syms[$];
    logic [9:0] words[$];
    logic       exp_de[$];
    logic [7:0] exp_data[$];
    logic [1:0] exp_ctl[$];

    tmds_decoder #(
        .CTRL_RUN(CTRL_RUN),
        .SEARCH_TIMEOUT(SEARCH_TO),
        .LOSS_TIMEOUT(LOSS_TO)
    ) dut (
        .i_pixclk(clk),
        .i_reset(rst),
        .i_tmds(tmds),
        .o_locked(locked),
        .o_offset(offset),
        .o_de(de),
        .o_data(data),
        .o_ctl(ctl)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [9:0] w);
        tmds = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tmds = 10'h000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Holds one word on the input until lock or the budget runs out.
    task automatic run_until_lock(input logic [9:0] w, input int max_ticks, output int n_out);
        n_out = -1;
        for (int n = 0; n < max_ticks; n++) begin
            tick(w);
            if (locked === 1'b1) begin
                n_out = n;
                break;
            end
        end
    endtask

    // TMDS stage-1/2 encoder, as in the transmitter.
    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic use_xnor, input logic inv);
        logic [7:0] qm;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        return {inv, ~use_xnor, (inv ? ~qm : qm)};
    endfunction

    function automatic logic is_tok(input logic [9:0] s);
        return (s == tok_tab[0]) || (s == tok_tab[1]) || (s == tok_tab[2]) || (s == tok_tab[3]);
    endfunction

    // Serialise syms LSB-first behind p idle bits and cut into 10-bit words.
    task automatic build_words(input int p);
        bit bq[$];
        words.delete();
        for (int i = 0; i < p; i++) bq.push_back(1'b0);
        foreach (syms[j])
            for (int b = 0; b < 10; b++) bq.push_back(syms[j][b]);
        while ((bq.size() % 10) != 0) bq.push_back(1'b0);
        for (int i = 0; i < 20; i++) bq.push_back(1'b0);
        for (int k = 0; k < bq.size() / 10; k++) begin
            logic [9:0] w;
            for (int b = 0; b < 10; b++) w[b] = bq[10*k + b];
            words.push_back(w);
        end
    endtask

    // Random mix of tokens and encoded bytes after a 0x354 preamble at a random phase.
    task automatic random_run();
        int         p;
        logic [1:0] last_ctl;
        p = $urandom_range(0, 9);
        syms.delete(); exp_de.delete(); exp_data.delete(); exp_ctl.delete();
        last_ctl = 2'b00;
        for (int i = 0; i < 200; i++) begin
            syms.push_back(tok_tab[0]);
            exp_de.push_back(1'b0); exp_data.push_back(8'h00); exp_ctl.push_back(2'b00);
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                logic [1:0] c;
                c = 2'($urandom_range(0, 3));
                last_ctl = c;
                syms.push_back(tok_tab[c]);
                exp_de.push_back(1'b0); exp_data.push_back(8'h00); exp_ctl.push_back(c);
            end else begin
                logic [7:0] byt;
                logic [9:0] s;
                do begin
                    byt = 8'($urandom);
                    s   = tmds_enc(byt, 1'($urandom), 1'($urandom));
                end while (is_tok(s));
                syms.push_back(s);
                exp_de.push_back(1'b1); exp_data.push_back(byt); exp_ctl.push_back(last_ctl);
            end
        end
        build_words(p);
        do_reset();
        for (int n = 0; n < words.size(); n++) begin
            int idx;
            tick(words[n]);
            idx = n - 2;
            if (idx >= 200 && idx < syms.size()) begin
                check("rand_locked", locked, 1'b1);
                check("rand_offset", offset, p);
                check("rand_de",     de,     exp_de[idx]);
                check("rand_data",   data,   exp_data[idx]);
                check("rand_ctl",    ctl,    exp_ctl[idx]);
            end
        end
    endtask

    initial begin
        int n_lock;
        int prev_off;
        bit wrapped;

        tok_tab[0] = 10'h354; tok_tab[1] = 10'h0AB; tok_tab[2] = 10'h154; tok_tab[3] = 10'h2AB;

        tab[0] = '{10'h100, 1'b1, 8'h00, 2'b00};
        tab[1] = '{10'h200, 1'b1, 8'hFF, 2'b00};
        tab[2] = '{10'h154, 1'b0, 8'h00, 2'b10};
        tab[3] = '{10'h155, 1'b1, 8'hFF, 2'b10};
        tab[4] = '{10'h0FF, 1'b1, 8'hFF, 2'b10};
        tab[5] = '{10'h2AB, 1'b0, 8'h00, 2'b11};
        tab[6] = '{10'h3F0, 1'b1, 8'h11, 2'b11};
        tab[7] = '{10'h1AA, 1'b1, 8'hFE, 2'b11};
        tab[8] = '{10'h0AB, 1'b0, 8'h00, 2'b01};
        tab[9] = '{10'h354, 1'b0, 8'h00, 2'b00};

        // Reset state.
        rst  = 1'b1;
        tmds = 10'h354;
        @(posedge clk);
        #1;
        check("rst_locked", locked, 1'b0);
        check("rst_offset", offset, 4'd0);
        check("rst_de",     de,     1'b0);
        check("rst_data",   data,   8'h00);
        check("rst_ctl",    ctl,    2'b00);
        rst = 1'b0;

        // 0x354 at offset 0 locks within 11 cycles.
        run_until_lock(10'h354, 11, n_lock);
        check("lock_in_11", (n_lock >= 0), 1'b1);
        check("lock_offset", offset, 4'd0);
        check("lock_de",     de,     1'b0);
        check("lock_ctl",    ctl,    2'b00);

        // Decode table, 3-stage latency.
        for (int i = 0; i < 12; i++) begin
            tick((i < 10) ? tab[i].sym : 10'h354);
            if (i >= 2) begin
                check("tab_de",     de,     tab[i-2].de);
                check("tab_data",   data,   tab[i-2].data);
                check("tab_ctl",    ctl,    tab[i-2].ctl);
                check("tab_locked", locked, 1'b1);
            end
        end

        // Loss of lock under a long data stretch.
        for (int n = 0; n < LOSS_TO - 8; n++) tick(10'h200);
        check("loss_hold", locked, 1'b1);
        for (int n = 0; n < 16 && locked === 1'b1; n++) tick(10'h200);
        check("loss_drop",   locked, 1'b0);
        check("loss_offset", offset, 4'd1);
        check("loss_de",     de,     1'b0);
        check("loss_data",   data,   8'h00);

        // Relock: search walks offsets 1..9 and wraps to 0.
        wrapped  = 1'b0;
        prev_off = offset;
        n_lock   = -1;
        for (int n = 0; n < 300; n++) begin
            tick(10'h354);
            if (prev_off == 9 && offset == 4'd0) wrapped = 1'b1;
            prev_off = offset;
            if (locked === 1'b1) begin
                n_lock = n;
                break;
            end
        end
        check("relock",        (n_lock >= 0), 1'b1);
        check("relock_offset", offset,        4'd0);
        check("relock_wrap",   wrapped,       1'b1);

        // An interleaved data symbol restarts the run; lock lands on the timeout cycle.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            tick((n == 5) ? 10'h200 : 10'h354);
            if (n == 14) check("ilv_not_yet", locked, 1'b0);
        end
        check("ilv_lock_wins", locked, 1'b1);
        check("ilv_offset",    offset, 4'd0);

        // 0x2AB stream rotated by 7 bits.
        syms.delete();
        for (int i = 0; i < 300; i++) syms.push_back(10'h2AB);
        build_words(7);
        do_reset();
        n_lock = -1;
        for (int n = 0; n < words.size(); n++) begin
            tick(words[n]);
            if (locked === 1'b1) begin
                n_lock = n;
                break;
            end
        end
        check("rot_lock",   (n_lock >= 0),              1'b1);
        check("rot_after6", (n_lock >= 7 * SEARCH_TO),  1'b1);
        check("rot_offset", offset,                     4'd7);
        check("rot_ctl",    ctl,                        2'b11);

        // Asynchronous reset mid-frame.
        #2;
        rst = 1'b1;
        #1;
        check("arst_locked", locked, 1'b0);
        check("arst_offset", offset, 4'd0);
        check("arst_ctl",    ctl,    2'b00);
        check("arst_de",     de,     1'b0);
        #1;
        rst = 1'b0;
        run_until_lock(10'h354, 11, n_lock);
        check("arst_relock",  (n_lock >= 0), 1'b1);
        check("arst_off_rel", offset,        4'd0);

        // Randomised streams against the symbol-level scoreboard.
        for (int r = 0; r < 3; r++) random_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
